// File: rtl/align_accum_serial.sv
// align_accum_serial
// ------------------
// Sits directly after the 9-lane max-exponent stage of the MAC subsystem.
// It captures one set of nine product mantissas together with their
// exponents, signs, skip mask and the shared max exponent. It then
// right-aligns each mantissa to the max exponent and adds or subtracts it
// into a signed fixed-point accumulator, one lane per cycle. The finished
// sum is offered to the normalisation stage over a valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_valid / o_ready   upstream handshake (a set is accepted only in IDLE)
//   i_skip[8:0]         per-lane skip, bit 8 = lane 0
//   i_max_exp           max exponent of the set
//   i_exp, i_man        packed lane exponents / mantissa magnitudes, lane 0 in MS slice
//   i_sign[8:0]         lane signs (1 = negative), bit 8 = lane 0
//   o_valid / i_ready   downstream handshake
//   o_sum               two's-complement aligned sum (wraps modulo 2^ACC_W)
//   o_max_exp           captured max exponent
//   o_err               a non-skipped lane had exp > max_exp
//   o_sticky            (STICKY_EN only) a non-skipped lane lost nonzero bits in alignment
//
// Optional feature macro: STICKY_EN

module align_accum_serial #(
   parameter int EXP_W = 6,
   parameter int MAN_W = 22,
   parameter int ACC_W = 27
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [8:0]         i_skip,
   input  logic [EXP_W-1:0]   i_max_exp,
   input  logic [9*EXP_W-1:0] i_exp,
   input  logic [9*MAN_W-1:0] i_man,
   input  logic [8:0]         i_sign,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [ACC_W-1:0]   o_sum,
   output logic [EXP_W-1:0]   o_max_exp,
   output logic               o_err
`ifdef STICKY_EN
   ,
   output logic               o_sticky
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Shifts at or beyond the mantissa width push every bit out.
   localparam logic [EXP_W-1:0] SHIFT_LIMIT = EXP_W'(MAN_W);
   localparam logic [3:0]       LAST_LANE   = 4'd8;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [3:0]         cnt_r;
   logic [8:0]         skip_r;
   logic [8:0]         sign_r;
   logic [9*EXP_W-1:0] exp_r;
   logic [9*MAN_W-1:0] man_r;
   logic [EXP_W-1:0]   max_exp_r;
   logic [ACC_W-1:0]   acc_r;
   logic               err_r;

   logic               lane_skip_s;
   logic               lane_sign_s;
   logic [EXP_W-1:0]   lane_exp_s;
   logic [MAN_W-1:0]   lane_man_s;
   logic [EXP_W-1:0]   shift_s;
   logic [ACC_W-1:0]   term_s;
   logic               lane_err_s;

   // The captured lane vectors are shifted left after every accumulate
   // cycle, so the lane being processed is always in the MS slice.
   // Lane datapath: alignment shift, aligned term and exponent error.
   always_comb begin
      lane_skip_s = skip_r[8];
      lane_sign_s = sign_r[8];
      lane_exp_s  = exp_r[9*EXP_W-1 -: EXP_W];
      lane_man_s  = man_r[9*MAN_W-1 -: MAN_W];
      shift_s     = {EXP_W{1'b0}};
      term_s      = {ACC_W{1'b0}};
      lane_err_s  = 1'b0;
      if (lane_skip_s) begin
         term_s = {ACC_W{1'b0}};
      end else begin
         // An exponent above the max is an upstream fault: flag it and
         // use the mantissa unshifted.
         if (lane_exp_s > max_exp_r) begin
            shift_s    = {EXP_W{1'b0}};
            lane_err_s = 1'b1;
         end else begin
            shift_s    = max_exp_r - lane_exp_s;
            lane_err_s = 1'b0;
         end
         if (shift_s >= SHIFT_LIMIT) begin
            term_s = {ACC_W{1'b0}};
         end else begin
            term_s = ACC_W'(lane_man_s >> shift_s);
         end
      end
   end

   // Next-state selection for the accept / accumulate / present sequence.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (i_valid) begin
               state_nxt_s = ACCUM;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCUM: begin
            if (cnt_r == LAST_LANE) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         DONE: begin
            if (i_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Capture at acceptance, then accumulate one lane per cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_r     <= 4'd0;
         skip_r    <= 9'd0;
         sign_r    <= 9'd0;
         exp_r     <= {(9*EXP_W){1'b0}};
         man_r     <= {(9*MAN_W){1'b0}};
         max_exp_r <= {EXP_W{1'b0}};
         acc_r     <= {ACC_W{1'b0}};
         err_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (i_valid) begin
                  cnt_r     <= 4'd0;
                  skip_r    <= i_skip;
                  sign_r    <= i_sign;
                  exp_r     <= i_exp;
                  man_r     <= i_man;
                  max_exp_r <= i_max_exp;
                  acc_r     <= {ACC_W{1'b0}};
                  err_r     <= 1'b0;
               end
            end
            ACCUM: begin
               if (lane_sign_s) begin
                  acc_r <= acc_r - term_s;
               end else begin
                  acc_r <= acc_r + term_s;
               end
               err_r  <= err_r | lane_err_s;
               cnt_r  <= cnt_r + 4'd1;
               skip_r <= skip_r << 1;
               sign_r <= sign_r << 1;
               exp_r  <= exp_r << EXP_W;
               man_r  <= man_r << MAN_W;
            end
            default: begin
               acc_r <= acc_r;
            end
         endcase
      end
   end

`ifdef STICKY_EN
   logic sticky_r;
   logic lane_lost_s;

   // Bits below the alignment point for a given shift.
   function automatic logic [MAN_W-1:0] low_mask(input logic [EXP_W-1:0] sh);
      return ~({MAN_W{1'b1}} << sh);
   endfunction

   // Detect nonzero bits discarded by this lane's alignment.
   always_comb begin
      lane_lost_s = 1'b0;
      if (lane_skip_s) begin
         lane_lost_s = 1'b0;
      end else if (shift_s >= SHIFT_LIMIT) begin
         lane_lost_s = (lane_man_s != {MAN_W{1'b0}});
      end else begin
         lane_lost_s = ((lane_man_s & low_mask(shift_s)) != {MAN_W{1'b0}});
      end
   end

   // Sticky flag: cleared at acceptance, accumulated across lanes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sticky_r <= 1'b0;
      end else if ((state_r == IDLE) && i_valid) begin
         sticky_r <= 1'b0;
      end else if (state_r == ACCUM) begin
         sticky_r <= sticky_r | lane_lost_s;
      end
   end

   assign o_sticky = sticky_r;
`endif

   assign o_ready   = (state_r == IDLE);
   assign o_valid   = (state_r == DONE);
   assign o_sum     = acc_r;
   assign o_max_exp = max_exp_r;
   assign o_err     = err_r;

endmodule

// File: tb/tb_align_accum_serial.sv
module tb_align_accum_serial;

   localparam int EXP_W = 6;
   localparam int MAN_W = 22;
   localparam int ACC_W = 27;

   logic               clk;
   logic               i_rst_n;
   logic               i_valid;
   logic               o_ready;
   logic [8:0]         i_skip;
   logic [EXP_W-1:0]   i_max_exp;
   logic [9*EXP_W-1:0] i_exp;
   logic [9*MAN_W-1:0] i_man;
   logic [8:0]         i_sign;
   logic               o_valid;
   logic               i_ready;
   logic [ACC_W-1:0]   o_sum;
   logic [EXP_W-1:0]   o_max_exp;
   logic               o_err;
`ifdef STICKY_EN
   logic               o_sticky;
`endif

   align_accum_serial #(.EXP_W(EXP_W), .MAN_W(MAN_W), .ACC_W(ACC_W)) dut (
      .i_clk     (clk),
      .i_rst_n   (i_rst_n),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_skip    (i_skip),
      .i_max_exp (i_max_exp),
      .i_exp     (i_exp),
      .i_man     (i_man),
      .i_sign    (i_sign),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_sum     (o_sum),
      .o_max_exp (o_max_exp),
      .o_err     (o_err)
`ifdef STICKY_EN
      ,
      .o_sticky  (o_sticky)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Current set (lane k indexed directly, k = 0..8).
   logic [8:0]       t_skip;
   logic [8:0]       t_sign;
   logic [EXP_W-1:0] t_max;
   logic [EXP_W-1:0] t_exp [9];
   logic [MAN_W-1:0] t_man [9];

   // Model expectations for the set in flight.
   longint exp_sum;
   longint exp_err;
   longint exp_stk;
   longint exp_max;

   // DUT values captured at DONE, pinned against hand-computed literals.
   longint got_sum;
   longint got_err;
   longint got_stk;

   task automatic chk(input string nm, input longint act, input longint req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   // Reference: plain integer arithmetic, division for alignment.
   task automatic model();
      longint s, term, m, p;
      int sh;
      bit er, st;
      s = 0; er = 0; st = 0;
      for (int k = 0; k < 9; k++) begin
         if (t_skip[8-k]) continue;
         m = longint'(t_man[k]);
         if (int'(t_exp[k]) > int'(t_max)) begin
            er = 1'b1;
            sh = 0;
         end else begin
            sh = int'(t_max) - int'(t_exp[k]);
         end
         if (sh >= MAN_W) begin
            term = 0;
            if (m != 0) st = 1'b1;
         end else begin
            p = 64'sd1 <<< sh;
            term = m / p;
            if ((m % p) != 0) st = 1'b1;
         end
         if (t_sign[8-k]) s = s - term;
         else             s = s + term;
      end
      exp_sum = s & ((64'sd1 <<< ACC_W) - 1);
      exp_err = longint'(er);
      exp_stk = longint'(st);
      exp_max = longint'(t_max);
   endtask

   task automatic scramble();
      i_exp     = (9*EXP_W)'({$urandom(), $urandom()});
      i_man     = (9*MAN_W)'({$urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom()});
      i_skip    = 9'($urandom());
      i_sign    = 9'($urandom());
      i_max_exp = EXP_W'($urandom());
   endtask

   task automatic drive();
      i_skip    = t_skip;
      i_sign    = t_sign;
      i_max_exp = t_max;
      for (int k = 0; k < 9; k++) begin
         i_exp[(8-k)*EXP_W +: EXP_W] = t_exp[k];
         i_man[(8-k)*MAN_W +: MAN_W] = t_man[k];
      end
   endtask

   task automatic set_all(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
      for (int k = 0; k < 9; k++) begin
         t_exp[k] = e;
         t_man[k] = m;
      end
   endtask

   // Offer one set, check latency, optionally stall in DONE, then release.
   task automatic run_set(input int hold);
      int n;
      @(negedge clk);
      drive();
      model();
      i_valid = 1'b1;
      chk("ready_before_accept", longint'(o_ready), 1);
      @(posedge clk); #1;
      i_valid = 1'b0;
      scramble();
      chk("ready_in_accum", longint'(o_ready), 0);
      n = 0;
      while (!o_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("valid_latency", longint'(n), 9);
      chk("ready_in_done", longint'(o_ready), 0);
      got_sum = longint'(o_sum);
      got_err = longint'(o_err);
`ifdef STICKY_EN
      got_stk = longint'(o_sticky);
`else
      got_stk = 0;
`endif
      repeat (hold) begin
         i_valid = 1'b1;
         scramble();
         @(posedge clk); #1;
         chk("hold_valid", longint'(o_valid), 1);
         chk("hold_ready", longint'(o_ready), 0);
         chk("hold_sum", longint'(o_sum), exp_sum);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_valid", longint'(o_valid), 0);
      chk("release_ready", longint'(o_ready), 1);
      i_ready = 1'b0;
   endtask

   // Output compare against the model whenever a result is presented.
   always @(negedge clk) begin
      if (i_rst_n && o_valid) begin
         chk("sum", longint'(o_sum), exp_sum);
         chk("err", longint'(o_err), exp_err);
         chk("max_exp", longint'(o_max_exp), exp_max);
`ifdef STICKY_EN
         chk("sticky", longint'(o_sticky), exp_stk);
`endif
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_skip = 9'd0; i_sign = 9'd0; i_max_exp = '0; i_exp = '0; i_man = '0;
      exp_sum = 0; exp_err = 0; exp_stk = 0; exp_max = 0;
      #3 i_rst_n = 1'b0;
      #2;
      chk("rst_ready", longint'(o_ready), 1);
      chk("rst_valid", longint'(o_valid), 0);
      chk("rst_sum", longint'(o_sum), 0);
      chk("rst_max_exp", longint'(o_max_exp), 0);
      chk("rst_err", longint'(o_err), 0);
`ifdef STICKY_EN
      chk("rst_sticky", longint'(o_sticky), 0);
`endif
      repeat (2) @(negedge clk);
      i_rst_n = 1'b1;

      // All nine lanes aligned, 9 x 1024.
      t_skip = 9'b000000000; t_sign = 9'b000000000; t_max = 6'd15;
      set_all(6'd15, 22'd1024);
      run_set(0);
      chk("lit_all_equal_sum", got_sum, 9216);
      chk("lit_all_equal_err", got_err, 0);

      // Only lane 0, shifted by 2; skipped lanes hold junk.
      t_skip = 9'b011111111; t_max = 6'd15;
      set_all(6'd0, 22'h3FFFFF);
      t_exp[0] = 6'd13; t_man[0] = 22'd1024;
      run_set(0);
      chk("lit_lane0_sum", got_sum, 256);
`ifdef STICKY_EN
      chk("lit_lane0_sticky", got_stk, 0);
`endif
      t_man[0] = 22'd1025;
      run_set(0);
      chk("lit_lane0_odd_sum", got_sum, 256);
`ifdef STICKY_EN
      chk("lit_lane0_odd_sticky", got_stk, 1);
`endif

      // Mixed signs, with a 5-cycle stall in DONE.
      t_skip = 9'b000000000; t_max = 6'd20;
      set_all(6'd20, 22'd100);
      t_sign = 9'b000001111;
      run_set(5);
      chk("lit_mixed_pos_sum", got_sum, 100);
      t_sign = 9'b111110000;
      run_set(0);
      chk("lit_mixed_neg_sum", got_sum, 134217628);

      // Lane 3 shifted out entirely, then lane 3 above max exponent.
      t_skip = 9'b111011111; t_sign = 9'b000000000; t_max = 6'd40;
      set_all(6'd63, 22'd77);
      t_exp[3] = 6'd10; t_man[3] = 22'h3FFFFF;
      run_set(0);
      chk("lit_shift_out_sum", got_sum, 0);
      chk("lit_shift_out_err", got_err, 0);
      t_exp[3] = 6'd41;
      run_set(0);
      chk("lit_exp_over_sum", got_sum, 4194303);
      chk("lit_exp_over_err", got_err, 1);

      // Assorted shifts and signs; skipped lane 0 has an oversize exponent.
      t_skip = 9'b100000000; t_sign = 9'b001010010; t_max = 6'd30;
      t_exp[0] = 6'd63; t_man[0] = 22'd5;
      t_exp[1] = 6'd30; t_man[1] = 22'h3FFFFF;
      t_exp[2] = 6'd29; t_man[2] = 22'd12345;
      t_exp[3] = 6'd27; t_man[3] = 22'd7;
      t_exp[4] = 6'd25; t_man[4] = 22'h200000;
      t_exp[5] = 6'd20; t_man[5] = 22'd999999;
      t_exp[6] = 6'd10; t_man[6] = 22'h3FFFFF;
      t_exp[7] = 6'd8;  t_man[7] = 22'd5;
      t_exp[8] = 6'd29; t_man[8] = 22'd1000;
      run_set(1);

      // A few pseudo-random sets checked by the model alone.
      for (int r = 0; r < 4; r++) begin
         t_skip = 9'($urandom());
         t_sign = 9'($urandom());
         t_max  = EXP_W'($urandom_range(0, 50));
         for (int k = 0; k < 9; k++) begin
            t_exp[k] = EXP_W'($urandom_range(0, 52));
            t_man[k] = MAN_W'($urandom());
         end
         run_set(r);
      end

      // Reset while lane 4 is being accumulated.
      t_skip = 9'b000000000; t_sign = 9'b000000000; t_max = 6'd15;
      set_all(6'd15, 22'd1024);
      @(negedge clk);
      drive();
      model();
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_max_exp_before", longint'(o_max_exp), 15);
      chk("abort_valid_before", longint'(o_valid), 0);
      i_rst_n = 1'b0;
      #1;
      chk("abort_sum", longint'(o_sum), 0);
      chk("abort_valid", longint'(o_valid), 0);
      chk("abort_err", longint'(o_err), 0);
      chk("abort_max_exp", longint'(o_max_exp), 0);
      repeat (2) @(negedge clk);
      i_rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_ready_after", longint'(o_ready), 1);

      // Fresh all-skip set.
      t_skip = 9'b111111111; t_sign = 9'b101010101; t_max = 6'd3;
      set_all(6'd60, 22'h3FFFFF);
      run_set(0);
      chk("lit_all_skip_sum", got_sum, 0);
      chk("lit_all_skip_err", got_err, 0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
